// File: rtl/vn_cycle_controller_if.sv
// ---------------------------------------------------------------------------
// vn_cycle_controller_if
// Shared-memory bus between the cycle controller and the single system
// memory. The controller drives the address and the gated write enable, and
// the memory returns read data.
//
//   mem_addr   controller -> memory   word address (ADDR_W)
//   mem_we     controller -> memory   write enable, already gated
//   mem_rdata  memory -> controller   read data (DATA_W)
//
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface vn_cycle_controller_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, output mem_rdata);
endinterface

// File: rtl/vn_cycle_controller.sv
// ---------------------------------------------------------------------------
// vn_cycle_controller
// Multi-cycle fetch/execute sequencer for the shared-memory CPU. Owns the
// memory address mux, write gating, PC enable and the instruction register.
// Supports a configurable memory read latency, a load-wait phase, single-step
// mode, a latched halt state and retired-instruction / cycle counters.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   bus (master)        mem_addr / mem_we out, mem_rdata in
//   pc_addr, alu_addr   PC and effective data address from the datapath
//   dp_mem_sel, dp_mem_we, dp_halt
//                       datapath requests, honoured only while ir_valid
//   step_mode, step     single-step control (step sampled in IDLE)
//   ir, ir_valid        latched instruction and its validity
//   ld_valid            mem_rdata carries valid load data this cycle
//   pc_en               datapath may advance the PC (once per retire)
//   halted, halt_pulse  HALT state and one-cycle pulse on entry
//   phase               IDLE=4, FETCH=0, EXEC=1, LOAD=2, HALT=3
//   instr_count         retired instructions (wraps)
//   cycle_count         non-reset, non-HALT cycles (wraps)
// ---------------------------------------------------------------------------
module vn_cycle_controller #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  vn_cycle_controller_if.master bus,
  input  logic [ADDR_W-1:0]   pc_addr,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic                dp_mem_sel,
  input  logic                dp_mem_we,
  input  logic                dp_halt,
  input  logic                step_mode,
  input  logic                step,
  output logic [DATA_W-1:0]   ir,
  output logic                ir_valid,
  output logic                ld_valid,
  output logic                pc_en,
  output logic                halted,
  output logic                halt_pulse,
  output logic [2:0]          phase,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    LOAD  = 3'd2,
    HALT  = 3'd3,
    IDLE  = 3'd4
  } state_t;

  // Last wait-counter value of a memory access; the address has then been
  // held for MEM_LATENCY cycles and mem_rdata may be sampled.
  localparam logic [3:0]       LAST    = 4'(MEM_LATENCY - 1);
  localparam bit               SINGLE  = (MEM_LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       capture, retire, go_halt, addr_alu, we_req, ld_req;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    capture  = 1'b0;
    retire   = 1'b0;
    go_halt  = 1'b0;
    addr_alu = 1'b0;
    we_req   = 1'b0;
    ld_req   = 1'b0;
    case (state)
      IDLE: begin
        if (step) state_n = FETCH;
      end
      FETCH: begin
        if (cnt == LAST) begin
          capture = 1'b1;
          cnt_n   = 4'd0;
          state_n = EXEC;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      EXEC: begin
        // Halt outranks any memory request decoded in the same instruction.
        if (dp_halt) begin
          go_halt = 1'b1;
          state_n = HALT;
        end else if (dp_mem_sel && !dp_mem_we) begin
          addr_alu = 1'b1;
          if (SINGLE) begin
            ld_req = 1'b1;
            retire = 1'b1;
          end else begin
            // EXEC already counts as the first cycle of the load address.
            cnt_n   = 4'd1;
            state_n = LOAD;
          end
        end else if (dp_mem_sel) begin
          addr_alu = 1'b1;
          we_req   = 1'b1;
          retire   = 1'b1;
        end else begin
          // dp_mem_we without dp_mem_sel is not a store; write stays off.
          retire = 1'b1;
        end
      end
      LOAD: begin
        addr_alu = 1'b1;
        if (cnt == LAST) begin
          ld_req = 1'b1;
          retire = 1'b1;
          cnt_n  = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      HALT: begin
      end
      default: begin
        state_n = FETCH;
      end
    endcase
    // step_mode is looked at only on the retiring cycle.
    if (retire) state_n = step_mode ? IDLE : FETCH;
  end

  // Strobes are masked during reset so an in-flight store never lands.
  assign bus.mem_addr = addr_alu ? alu_addr : pc_addr;
  assign bus.mem_we   = we_req & ~reset;
  assign pc_en        = retire & ~reset;
  assign ld_valid     = ld_req & ~reset;
  assign ir_valid     = ((state == EXEC) || (state == LOAD)) & ~reset;
  assign halted       = (state == HALT) & ~reset;
  assign phase        = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= step_mode ? IDLE : FETCH;
      cnt         <= 4'd0;
      ir          <= '0;
      instr_count <= '0;
      cycle_count <= '0;
      halt_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      halt_pulse <= go_halt;
      if (capture) ir <= bus.mem_rdata;
      if (retire) instr_count <= instr_count + CNT_ONE;
      if (state != HALT) cycle_count <= cycle_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_vn_cycle_controller.sv
// ---------------------------------------------------------------------------
// tb_vn_cycle_controller
// Bench for vn_cycle_controller. Three instances with read latencies 1, 3
// and 4 share the stimulus; each scenario selects one instance and checks it
// against an instruction-level model: an instruction of a given kind takes a
// known number of cycles with a known phase sequence, strobes land on known
// cycles, and the counters advance by whole instructions / cycles.
// ---------------------------------------------------------------------------
module tb_vn_cycle_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, step_mode, step, dp_mem_sel, dp_mem_we, dp_halt;
  logic [7:0]  pc_addr, alu_addr;
  logic [15:0] st_data;
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  int LATS [3] = '{1, 3, 4};
  int sel;
  int n_chk = 0;
  int n_pass = 0;
  int exp_ic, exp_cc;

  vn_cycle_controller_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
  vn_cycle_controller_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
  vn_cycle_controller_if #(.ADDR_W(8), .DATA_W(16)) b2 ();

  assign b0.mem_rdata = mem[b0.mem_addr];
  assign b1.mem_rdata = mem[b1.mem_addr];
  assign b2.mem_rdata = mem[b2.mem_addr];

  logic [7:0]  o_addr [3];
  logic        o_we   [3];
  logic [15:0] o_rd   [3];
  logic [15:0] o_ir   [3];
  logic        o_irv  [3];
  logic        o_ld   [3];
  logic        o_pc   [3];
  logic        o_hl   [3];
  logic        o_hp   [3];
  logic [2:0]  o_ph   [3];
  logic [15:0] o_ic   [3];
  logic [15:0] o_cc   [3];

  assign o_addr[0] = b0.mem_addr;
  assign o_addr[1] = b1.mem_addr;
  assign o_addr[2] = b2.mem_addr;
  assign o_we[0]   = b0.mem_we;
  assign o_we[1]   = b1.mem_we;
  assign o_we[2]   = b2.mem_we;
  assign o_rd[0]   = b0.mem_rdata;
  assign o_rd[1]   = b1.mem_rdata;
  assign o_rd[2]   = b2.mem_rdata;

  vn_cycle_controller #(.ADDR_W(8), .DATA_W(16), .MEM_LATENCY(1), .CNT_W(16)) u_lat1 (
    .clock(clock), .reset(reset), .bus(b0), .pc_addr(pc_addr), .alu_addr(alu_addr),
    .dp_mem_sel(dp_mem_sel), .dp_mem_we(dp_mem_we), .dp_halt(dp_halt),
    .step_mode(step_mode), .step(step), .ir(o_ir[0]), .ir_valid(o_irv[0]),
    .ld_valid(o_ld[0]), .pc_en(o_pc[0]), .halted(o_hl[0]), .halt_pulse(o_hp[0]),
    .phase(o_ph[0]), .instr_count(o_ic[0]), .cycle_count(o_cc[0]));

  vn_cycle_controller #(.ADDR_W(8), .DATA_W(16), .MEM_LATENCY(3), .CNT_W(16)) u_lat3 (
    .clock(clock), .reset(reset), .bus(b1), .pc_addr(pc_addr), .alu_addr(alu_addr),
    .dp_mem_sel(dp_mem_sel), .dp_mem_we(dp_mem_we), .dp_halt(dp_halt),
    .step_mode(step_mode), .step(step), .ir(o_ir[1]), .ir_valid(o_irv[1]),
    .ld_valid(o_ld[1]), .pc_en(o_pc[1]), .halted(o_hl[1]), .halt_pulse(o_hp[1]),
    .phase(o_ph[1]), .instr_count(o_ic[1]), .cycle_count(o_cc[1]));

  vn_cycle_controller #(.ADDR_W(8), .DATA_W(16), .MEM_LATENCY(4), .CNT_W(16)) u_lat4 (
    .clock(clock), .reset(reset), .bus(b2), .pc_addr(pc_addr), .alu_addr(alu_addr),
    .dp_mem_sel(dp_mem_sel), .dp_mem_we(dp_mem_we), .dp_halt(dp_halt),
    .step_mode(step_mode), .step(step), .ir(o_ir[2]), .ir_valid(o_irv[2]),
    .ld_valid(o_ld[2]), .pc_en(o_pc[2]), .halted(o_hl[2]), .halt_pulse(o_hp[2]),
    .phase(o_ph[2]), .instr_count(o_ic[2]), .cycle_count(o_cc[2]));

  // Instruction kinds used by the model.
  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_HLT = 3;

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
  endtask

  // One reset cycle (with strobes requested, to show they are masked), then
  // release and check the post-reset state. Returns mid-cycle in the first
  // post-reset cycle with no further edge consumed.
  task automatic do_reset(input int s, input logic sm);
    logic [4:0] got;
    sel        = s;
    reset      = 1'b1;
    step_mode  = sm;
    step       = 1'b0;
    dp_mem_sel = 1'b1;
    dp_mem_we  = 1'b1;
    dp_halt    = 1'b0;
    #1;
    got = {o_we[sel], o_pc[sel], o_ld[sel], o_irv[sel], o_hl[sel]};
    n_chk++;
    if (got !== 5'b0) $display("FAIL reset_cycle_strobes inst=%0d got=%b want=00000", sel, got);
    else n_pass++;
    @(negedge clock);
    reset      = 1'b0;
    dp_mem_sel = 1'b0;
    dp_mem_we  = 1'b0;
    exp_ic     = 0;
    exp_cc     = 0;
    #1;
    n_chk++;
    if (o_ph[sel] !== (sm ? 3'd4 : 3'd0) || o_ir[sel] !== 16'h0 || o_ic[sel] !== 16'h0 ||
        o_cc[sel] !== 16'h0 || o_hp[sel] !== 1'b0)
      $display("FAIL reset_state inst=%0d phase=%0d ir=%h ic=%0d cc=%0d hp=%b want phase=%0d zeros",
               sel, o_ph[sel], o_ir[sel], o_ic[sel], o_cc[sel], o_hp[sel], sm ? 4 : 0);
    else n_pass++;
  endtask

  // Runs one instruction from its first FETCH cycle to its retire (or HALT
  // entry). Returns at the falling edge of the cycle after it.
  task automatic run_instr(input int kind, input logic [7:0] pc, input logic [7:0] aa,
                           input logic [15:0] sd, input logic sm);
    int         lat, n;
    logic [8:0] exp_v, got_v;
    logic [7:0] exp_a;
    lat = LATS[sel];
    n = lat + 1 + ((kind == K_LD && lat > 1) ? lat - 1 : 0);
    pc_addr    = pc;
    alu_addr   = aa;
    st_data    = sd;
    dp_halt    = (kind == K_HLT);
    dp_mem_sel = (kind != K_ALU);
    dp_mem_we  = (kind == K_ST) || (kind == K_HLT) || (kind == K_ALU && 1'($urandom));
    for (int c = 0; c < n; c++) begin
      step_mode = (c == n - 1) ? sm : 1'($urandom);
      step      = 1'($urandom);
      #1;
      exp_v[8:6] = (c < lat) ? 3'd0 : (c == lat) ? 3'd1 : 3'd2;
      exp_v[5]   = (c == lat) && (kind == K_ST);
      exp_v[4]   = (c == n - 1) && (kind != K_HLT);
      exp_v[3]   = (c == n - 1) && (kind == K_LD);
      exp_v[2]   = (c >= lat);
      exp_v[1:0] = 2'b00;
      got_v = {o_ph[sel], o_we[sel], o_pc[sel], o_ld[sel], o_irv[sel], o_hl[sel], o_hp[sel]};
      n_chk++;
      if (got_v !== exp_v)
        $display("FAIL ctl inst=%0d kind=%0d cyc=%0d got ph,we,pc,ld,irv,hl,hp=%b want=%b",
                 sel, kind, c, got_v, exp_v);
      else n_pass++;
      if (!(kind == K_HLT && c == lat)) begin
        exp_a = (c >= lat && (kind == K_LD || kind == K_ST)) ? aa : pc;
        n_chk++;
        if (o_addr[sel] !== exp_a)
          $display("FAIL mem_addr inst=%0d kind=%0d cyc=%0d got=%h want=%h", sel, kind, c, o_addr[sel], exp_a);
        else n_pass++;
      end
      n_chk++;
      if (o_ic[sel] !== 16'(exp_ic) || o_cc[sel] !== 16'(exp_cc + c))
        $display("FAIL counters inst=%0d cyc=%0d got ic=%0d cc=%0d want ic=%0d cc=%0d",
                 sel, c, o_ic[sel], o_cc[sel], exp_ic, exp_cc + c);
      else n_pass++;
      if (c >= lat) begin
        n_chk++;
        if (o_ir[sel] !== ref_mem[pc])
          $display("FAIL ir inst=%0d cyc=%0d got=%h want=%h", sel, c, o_ir[sel], ref_mem[pc]);
        else n_pass++;
      end
      if (c == n - 1 && kind == K_LD) begin
        n_chk++;
        if (o_rd[sel] !== ref_mem[aa])
          $display("FAIL load_data inst=%0d got=%h want=%h", sel, o_rd[sel], ref_mem[aa]);
        else n_pass++;
      end
      if (o_we[sel]) mem[o_addr[sel]] = sd;
      @(negedge clock);
    end
    if (kind == K_ST) ref_mem[aa] = sd;
    exp_cc += n;
    if (kind != K_HLT) exp_ic++;
  endtask

  // IDLE cycles; with go=1 the last one carries the step request.
  task automatic idle_wait(input int cycles, input logic go);
    logic [8:0] got_v;
    for (int i = 0; i < cycles; i++) begin
      step       = go && (i == cycles - 1);
      dp_mem_sel = 1'($urandom);
      dp_mem_we  = 1'($urandom);
      dp_halt    = 1'($urandom);
      #1;
      got_v = {o_ph[sel], o_we[sel], o_pc[sel], o_ld[sel], o_irv[sel], o_hl[sel], o_hp[sel]};
      n_chk++;
      if (got_v !== 9'b100_000000 || o_addr[sel] !== pc_addr)
        $display("FAIL idle inst=%0d i=%0d got ctl=%b addr=%h want ctl=100000000 addr=%h",
                 sel, i, got_v, o_addr[sel], pc_addr);
      else n_pass++;
      n_chk++;
      if (o_cc[sel] !== 16'(exp_cc) || o_ic[sel] !== 16'(exp_ic))
        $display("FAIL idle_counters inst=%0d got ic=%0d cc=%0d want ic=%0d cc=%0d",
                 sel, o_ic[sel], o_cc[sel], exp_ic, exp_cc);
      else n_pass++;
      @(negedge clock);
      exp_cc++;
    end
    step = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      do_reset(s, 1'b0);
      @(negedge clock);
      do_reset(s, 1'b1);
      @(negedge clock);
    end
  endtask

  task automatic test_alu_lat1();
    init_mem();
    do_reset(0, 1'b0);
    run_instr(K_ALU, 8'h00, 8'h33, 16'h0, 1'b0);
    run_instr(K_ALU, 8'h01, 8'h44, 16'h0, 1'b0);
    run_instr(K_LD,  8'h02, 8'h80, 16'h0, 1'b0);
  endtask

  task automatic test_load_lat3();
    init_mem();
    mem[8'h40]     = 16'hBEEF;
    ref_mem[8'h40] = 16'hBEEF;
    do_reset(1, 1'b0);
    run_instr(K_LD, 8'h00, 8'h40, 16'h0, 1'b0);
    run_instr(K_ALU, 8'h01, 8'h41, 16'h0, 1'b0);
  endtask

  task automatic test_store();
    for (int s = 0; s < 2; s++) begin
      init_mem();
      do_reset(s, 1'b0);
      run_instr(K_ALU, 8'h00, 8'h10, 16'h0, 1'b0);
      run_instr(K_ST,  8'h01, 8'h10, 16'h1234, 1'b0);
      n_chk++;
      if (mem[8'h10] !== 16'h1234)
        $display("FAIL store_mem inst=%0d got=%h want=1234", sel, mem[8'h10]);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic [8:0] got_v;
    init_mem();
    do_reset(2, 1'b0);
    run_instr(K_ALU, 8'h05, 8'h20, 16'h0, 1'b0);
    run_instr(K_HLT, 8'h06, 8'h20, 16'hAAAA, 1'b0);
    for (int i = 0; i < 20; i++) begin
      pc_addr    = 8'($urandom);
      dp_mem_sel = 1'($urandom);
      dp_mem_we  = 1'($urandom);
      step       = 1'($urandom);
      step_mode  = 1'($urandom);
      #1;
      got_v = {o_ph[sel], o_we[sel], o_pc[sel], o_ld[sel], o_irv[sel], o_hl[sel], o_hp[sel]};
      n_chk++;
      if (got_v !== {3'd3, 4'b0000, 1'b1, i == 0})
        $display("FAIL halt_ctl i=%0d got=%b want=%b", i, got_v, {3'd3, 4'b0000, 1'b1, i == 0});
      else n_pass++;
      n_chk++;
      if (o_ic[sel] !== 16'(exp_ic) || o_cc[sel] !== 16'(exp_cc) || o_ir[sel] !== ref_mem[8'h06])
        $display("FAIL halt_frozen i=%0d got ic=%0d cc=%0d ir=%h want ic=%0d cc=%0d ir=%h",
                 i, o_ic[sel], o_cc[sel], o_ir[sel], exp_ic, exp_cc, ref_mem[8'h06]);
      else n_pass++;
      @(negedge clock);
    end
    n_chk++;
    if (mem[8'h20] !== ref_mem[8'h20])
      $display("FAIL halt_no_write got=%h want=%h", mem[8'h20], ref_mem[8'h20]);
    else n_pass++;
  endtask

  task automatic test_step();
    init_mem();
    do_reset(0, 1'b1);
    pc_addr = 8'h07;
    idle_wait(10, 1'b0);
    idle_wait(1, 1'b1);
    run_instr(K_ALU, 8'h07, 8'h00, 16'h0, 1'b1);
    idle_wait(4, 1'b0);
    n_chk++;
    if (o_ic[sel] !== 16'd1) $display("FAIL step_retired got=%0d want=1", o_ic[sel]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] got4;
    // Store interrupted by reset in its EXEC cycle.
    init_mem();
    do_reset(0, 1'b0);
    pc_addr = 8'h02; alu_addr = 8'h20; dp_mem_sel = 1'b1; dp_mem_we = 1'b1; dp_halt = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_chk++;
    if (o_we[sel] !== 1'b0 || o_pc[sel] !== 1'b0)
      $display("FAIL reset_store we=%b pc_en=%b want 0 0", o_we[sel], o_pc[sel]);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    // Load on the latency-4 instance aborted in its second LOAD cycle.
    do_reset(2, 1'b0);
    pc_addr = 8'h03; alu_addr = 8'h55; dp_mem_sel = 1'b1; dp_mem_we = 1'b0; dp_halt = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++;
      if (o_ph[sel] !== ((c < 4) ? 3'd0 : (c == 4) ? 3'd1 : 3'd2) || o_pc[sel] !== 1'b0 || o_ld[sel] !== 1'b0)
        $display("FAIL abort_pre cyc=%0d ph=%0d pc_en=%b ld=%b", c, o_ph[sel], o_pc[sel], o_ld[sel]);
      else n_pass++;
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    got4 = {o_pc[sel], o_ld[sel], o_irv[sel], o_we[sel]};
    n_chk++;
    if (got4 !== 4'b0000) $display("FAIL abort_reset_cycle got pc,ld,irv,we=%b want=0000", got4);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    dp_mem_sel = 1'b0;
    exp_ic = 0;
    exp_cc = 0;
    #1;
    n_chk++;
    if (o_ph[sel] !== 3'd0 || o_ir[sel] !== 16'h0 || o_ic[sel] !== 16'h0 || o_cc[sel] !== 16'h0)
      $display("FAIL abort_after ph=%0d ir=%h ic=%0d cc=%0d want 0 0 0 0",
               o_ph[sel], o_ir[sel], o_ic[sel], o_cc[sel]);
    else n_pass++;
    run_instr(K_LD, 8'h03, 8'h55, 16'h0, 1'b0);
  endtask

  task automatic test_random();
    int   kind;
    logic sm;
    for (int s = 0; s < 3; s++) begin
      init_mem();
      do_reset(s, 1'b0);
      for (int k = 0; k < 25; k++) begin
        kind = int'($urandom_range(0, 2));
        sm   = 1'($urandom);
        run_instr(kind, 8'($urandom), 8'($urandom), 16'($urandom), sm);
        if (sm) begin
          pc_addr = 8'($urandom);
          idle_wait(int'($urandom_range(1, 3)), 1'b1);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; step_mode = 1'b0; step = 1'b0;
    dp_mem_sel = 1'b0; dp_mem_we = 1'b0; dp_halt = 1'b0;
    pc_addr = 8'h0; alu_addr = 8'h0; st_data = 16'h0;
    sel = 0; exp_ic = 0; exp_cc = 0;
    init_mem();
    @(negedge clock);
    test_reset();
    test_alu_lat1();
    test_load_lat3();
    test_store();
    test_halt();
    test_step();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vn_cycle_controller.md
Name: vn_cycle_controller

Overview:
Parametrised multi-cycle fetch/execute sequencer for the shared-memory (Von Neumann) CPU. It sits between the datapath and the single system memory, and owns the memory address mux, write gating, PC enable and the instruction register. Over the current fixed 2-state controller it adds:
- configurable memory read latency,
- a dedicated load-wait phase,
- single-step mode,
- a latched halt state,
- retired-instruction and cycle counters.

Parameters:
ADDR_W, 8, memory/PC address width
DATA_W, 16, instruction and memory word width
MEM_LATENCY, 1, cycles an address is held before mem_rdata is sampled (legal 1..8)
CNT_W, 16, width of instr_count and cycle_count

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
pc_addr  in  ADDR_W  current PC from datapath
alu_addr  in  ADDR_W  effective data address from datapath
mem_rdata  in  DATA_W  memory read data
dp_mem_sel  in  1  datapath requests data address (LD/ST); meaningful only while ir_valid
dp_mem_we  in  1  datapath requests store; meaningful only while ir_valid
dp_halt  in  1  datapath decoded HLT; meaningful only while ir_valid
step_mode  in  1  1 = wait for step pulse before each fetch
step  in  1  single-step request, level sampled in IDLE
mem_addr  out  ADDR_W  address to shared memory
mem_we  out  1  gated memory write enable
ir  out  DATA_W  latched instruction
ir_valid  out  1  ir holds the current instruction (EXEC or LOAD)
ld_valid  out  1  mem_rdata is valid load data this cycle
pc_en  out  1  datapath may update the PC this cycle
halted  out  1  controller in HALT
halt_pulse  out  1  one-cycle pulse on HALT entry
phase  out  3  state: IDLE=4, FETCH=0, EXEC=1, LOAD=2, HALT=3
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
cycle_count  out  CNT_W  cycles since reset, excluding HALT; wraps

Behaviour:
Reset:
- State goes to FETCH if step_mode=1'b0, else IDLE.
- ir=0, wait counter=0, instr_count=0, cycle_count=0, halt_pulse=0.
- In the reset cycle: mem_we=0, pc_en=0, ld_valid=0, ir_valid=0, halted=0.

Registered vs combinational outputs:
- Registered: state, ir, counters, halt_pulse.
- Combinational from state and inputs: mem_addr, mem_we, pc_en, ld_valid, ir_valid, halted, phase.

IDLE:
- mem_addr=pc_addr; no write, no pc_en.
- step=1 -> FETCH; otherwise stay.

FETCH:
- mem_addr=pc_addr; wait counter counts 0..MEM_LATENCY-1.
- On the cycle the counter equals MEM_LATENCY-1: ir<=mem_rdata, counter<=0, next EXEC.
- Fetch therefore takes MEM_LATENCY cycles; with MEM_LATENCY=1, fetch and execute are one cycle each (2-cycle instruction).

EXEC (ir_valid=1). Priority order:
1. dp_halt=1 -> HALT. No write, no pc_en; halt wins over a simultaneous store or load request.
2. Load (dp_mem_sel=1, dp_mem_we=0):
   - mem_addr=alu_addr.
   - If MEM_LATENCY=1: ld_valid=1 and pc_en=1 this cycle, then retire.
   - Otherwise counter<=1, next LOAD.
3. Store (dp_mem_sel=1, dp_mem_we=1): mem_addr=alu_addr, mem_we=1, pc_en=1, retire. A store is always single-cycle.
4. Otherwise (ALU/branch):
   - mem_addr=pc_addr; mem_we=dp_mem_we is forced to 0 when dp_mem_sel=0.
   - pc_en=1, retire.

LOAD (ir_valid=1):
- mem_addr=alu_addr; counter increments each cycle.
- On counter==MEM_LATENCY-1: ld_valid=1, pc_en=1, retire.
- mem_we=0 throughout.

Retire:
- instr_count increments.
- Next state is IDLE if step_mode=1, else FETCH.
- step_mode is sampled at the retire edge.

HALT:
- Absorbing until reset. mem_addr=pc_addr, mem_we=0, pc_en=0, halted=1.
- ir holds its value; counters freeze.
- halt_pulse=1 only in the first HALT cycle.

General rules:
- mem_we and pc_en are never asserted outside EXEC/LOAD.
- pc_en is asserted exactly once per retired instruction.
- cycle_count increments every non-reset cycle not in HALT, including IDLE.
- Reset asserted in any state (including mid-LOAD or mid-FETCH wait) takes effect at the next edge; a store in progress that cycle is suppressed (mem_we=0 while reset=1).
- Toggling step_mode mid-instruction affects only the next retire decision.

Test Plan:
1. MEM_LATENCY=1, memory word[0]=ALU op, pc_addr=0 -> ir captured at end of cycle 1, pc_en high in cycle 2, instr_count=1 after 2 cycles, phase sequence 0,1,0.
2. MEM_LATENCY=3, load with alu_addr=8'h40, mem[0x40]=16'hBEEF -> fetch 3 cycles, EXEC+2 LOAD cycles with mem_addr=8'h40, ld_valid and pc_en high together in the last LOAD cycle with mem_rdata=16'hBEEF; 6 cycles total.
3. Store with alu_addr=8'h10, data 16'h1234 -> mem_we high exactly one cycle (EXEC) with mem_addr=8'h10; mem[0x10]=16'h1234 afterwards; never high during FETCH.
4. HLT with dp_mem_we=1 and dp_mem_sel=1 simultaneously -> no write, halt_pulse one cycle, halted stays 1, counters frozen over 20 further cycles.
5. step_mode=1, step held low 10 cycles -> phase stays 4, no pc_en; one-cycle step pulse -> exactly one instruction retires, then back to IDLE.
6. Reset asserted mid-LOAD (MEM_LATENCY=4, second LOAD cycle) -> next cycle phase=0, ir=0, instr_count=0, ld_valid and pc_en never asserted for the aborted load.
